muldiv32: RTL and testbench

- Iterative multi-cycle multiply/divide unit for the MIPS core. Implements MULT, MULTU, DIV and DIVU, and owns the HI/LO architectural registers.
- Sits beside the combinational ALU. The decode/EX stage issues it through a start/busy/done handshake.
- MFHI/MFLO read the hi/lo ports directly. MTHI/MTLO write through dedicated write enables.

---
 rtl/muldiv32.sv | 220 ++++++++++++++++++++++
 tb/tb_muldiv32.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv32.sv
// muldiv32 -- iterative 32-bit multiply/divide unit that owns the MIPS HI/LO
// registers. It implements MULT, MULTU, DIV and DIVU with a 64-bit
// shift-add multiplier and a restoring divider. Both share one 64-bit
// accumulator and a 32-iteration RUN phase.
//
// Optional build macro: MULDIV_FAST_MUL_EN
//   When defined, MULT/MULTU use a single-cycle 64-bit combinational
//   multiply. Accept goes straight to FIX, so the result lands one edge later.
//   Divides keep the iterative path.
//
// Handshake (start / busy / done):
//   - start is accepted on a rising edge where busy=0. op, src_a and src_b are
//     sampled on that same edge.
//   - busy goes high after the accept edge. It stays high until the edge that
//     loads hi/lo.
//   - done is a one-cycle pulse in the cycle after hi/lo are loaded. busy is
//     already low in that cycle, so a new start may be accepted there.
//   - start, hi_we and lo_we are ignored while busy=1.
//   - If start and a write enable are both high while idle, start wins and
//     the write is dropped.

module muldiv32 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  // Operation context captured at accept.
  logic        is_div_q;   // 1: DIV/DIVU, 0: MULT/MULTU
  logic        neg_q;      // negate product / quotient in FIX
  logic        rneg_q;     // negate remainder in FIX (dividend was negative)
  logic        dz_q;       // divide by zero
  logic [31:0] orig_a_q;   // unmodified src_a, returned in HI on divide by zero
  logic [31:0] opnd_q;     // multiplicand magnitude or divisor magnitude

  // Multiply: {hi-part, multiplier}. Divide: {partial remainder, dividend/quotient}.
  logic [63:0] acc_q;

  // Accept-side operand preparation.
  logic        accept;
  logic        op_signed;
  logic        op_div;
  logic [31:0] a_mag;
  logic [31:0] b_mag;

  // Iteration datapath.
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_shift;
  logic [33:0] div_diff;
  logic [63:0] div_next;

  // Sign correction and final result selection.
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic [31:0] fix_hi;
  logic [31:0] fix_lo;

`ifdef MULDIV_FAST_MUL_EN
  logic [63:0] fast_prod;
`endif

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  // Convert signed operands to magnitudes and detect an accepted request.
  always_comb begin
    accept    = start & ~busy_q;
    op_div    = op[1];
    op_signed = ~op[0];
    a_mag     = (op_signed && src_a[31]) ? (32'd0 - src_a) : src_a;
    b_mag     = (op_signed && src_b[31]) ? (32'd0 - src_b) : src_b;
  end

`ifdef MULDIV_FAST_MUL_EN
  // Full-width product of the magnitudes for the single-cycle multiply.
  always_comb begin
    fast_prod = {32'd0, a_mag} * {32'd0, b_mag};
  end
`endif

  // One shift-add multiply step and one restoring-divide step.
  always_comb begin
    // Multiply: add the multiplicand when the multiplier LSB is set, then shift right.
    mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opnd_q : 32'd0)};
    mul_next = {mul_sum, acc_q[31:1]};

    // Divide: shift the next dividend bit into the remainder and try subtracting.
    // When the trial subtract fails, the shifted value is below the divisor,
    // so its bit 32 is clear and the low 32 bits hold the whole remainder.
    div_shift = {acc_q[63:32], acc_q[31]};
    div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
    if (div_diff[33]) begin
      div_next = {div_shift[31:0], acc_q[30:0], 1'b0};
    end else begin
      div_next = {div_diff[31:0], acc_q[30:0], 1'b1};
    end
  end

  // Apply result signs and choose what FIX writes into HI/LO.
  always_comb begin
    prod_fix = neg_q  ? (64'd0 - acc_q)        : acc_q;
    quo_fix  = neg_q  ? (32'd0 - acc_q[31:0])  : acc_q[31:0];
    rem_fix  = rneg_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
    if (dz_q) begin
      fix_hi = orig_a_q;
      fix_lo = 32'hFFFF_FFFF;
    end else if (is_div_q) begin
      fix_hi = rem_fix;
      fix_lo = quo_fix;
    end else begin
      fix_hi = prod_fix[63:32];
      fix_lo = prod_fix[31:0];
    end
  end

  // Control FSM, iteration datapath, and HI/LO architectural registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      orig_a_q <= 32'd0;
      opnd_q   <= 32'd0;
      acc_q    <= 64'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            // Start wins over MTHI/MTLO issued in the same cycle.
            is_div_q <= op_div;
            neg_q    <= op_signed & (src_a[31] ^ src_b[31]);
            rneg_q   <= op_signed & src_a[31];
            dz_q     <= op_div & (src_b == 32'd0);
            orig_a_q <= src_a;
            cnt_q    <= 5'd0;
            busy_q   <= 1'b1;
            if (op_div) begin
              opnd_q  <= b_mag;
              acc_q   <= {32'd0, a_mag};
              state_q <= S_RUN;
            end else begin
              opnd_q  <= a_mag;
`ifdef MULDIV_FAST_MUL_EN
              acc_q   <= fast_prod;
              state_q <= S_FIX;
`else
              acc_q   <= {32'd0, b_mag};
              state_q <= S_RUN;
`endif
            end
          end else begin
            if (hi_we) begin
              hi_q <= wdata;
            end
            if (lo_we) begin
              lo_q <= wdata;
            end
          end
        end

        S_RUN: begin
          acc_q <= is_div_q ? div_next : mul_next;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q <= S_FIX;
          end
        end

        S_FIX: begin
          hi_q    <= fix_hi;
          lo_q    <= fix_lo;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv32.sv
// tb_muldiv32 -- directed-vector bench for muldiv32. The driver pushes the
// expected {hi,lo} and the done cycle into queues when it issues a request.
// A monitor pops and compares them whenever done pulses.

module tb_muldiv32;

  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;

  localparam int LAT_DIV = 33;
`ifdef MULDIV_FAST_MUL_EN
  localparam int LAT_MUL = 1;
`else
  localparam int LAT_MUL = 33;
`endif

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  logic [63:0] exp_q[$];
  int          lat_q[$];
  int          cyc;
  int          total;
  int          bad;

  muldiv32 dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .src_a   (src_a),
    .src_b   (src_b),
    .hi_we   (hi_we),
    .lo_we   (lo_we),
    .wdata   (wdata),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  // Clock and cycle counter.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one request for a single cycle. The caller must ensure busy=0.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] e, input bit expect_it, input int lat);
    if (expect_it) exp_q.push_back(e);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    @(posedge clk);
    #1;
    if (expect_it) lat_q.push_back(cyc + lat);
    start = 1'b0;
  endtask

  // Wait for busy to drop, with a bounded budget.
  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      total++;
      bad++;
      $display("FAIL %s: timeout, busy=%b required 0", name, busy);
    end
  endtask

  task automatic run(input string name, input logic [1:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [63:0] e, input int lat);
    issue(o, a, b, e, 1'b1, lat);
    wait_idle(name);
  endtask

  // Monitor: compare every done pulse against the scoreboard.
  always @(negedge clk) begin
    if (reset_n && done) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got hi=%h lo=%h required no done", hi, lo);
      end else begin
        logic [63:0] e;
        int          l;
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        chk("result", {hi, lo}, e);
        chk("latency", 64'(cyc), 64'(l));
      end
    end
  end

  initial begin
    total   = 0;
    bad     = 0;
    reset_n = 1'b1;
    start   = 1'b0;
    op      = 2'd0;
    src_a   = 32'd0;
    src_b   = 32'd0;
    hi_we   = 1'b0;
    lo_we   = 1'b0;
    wdata   = 32'd0;

    // Reset state.
    #2 reset_n = 1'b0;
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Multiply vectors.
    run("mult_neg",   OP_MULT,  32'hFFFF_FFFE, 32'd3,         64'hFFFF_FFFF_FFFF_FFFA, LAT_MUL);
    run("multu",      OP_MULTU, 32'hFFFF_FFFE, 32'd3,         64'h0000_0002_FFFF_FFFA, LAT_MUL);
    run("multu_max",  OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, LAT_MUL);
    run("mult_min",   OP_MULT,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, LAT_MUL);

    // Divide vectors: {hi=remainder, lo=quotient}.
    run("div_neg_a",  OP_DIV,   32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD, LAT_DIV);
    run("div_neg_b",  OP_DIV,   32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, LAT_DIV);
    run("divu",       OP_DIVU,  32'd7,         32'd2,         64'h0000_0001_0000_0003, LAT_DIV);
    run("div_ovf",    OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, LAT_DIV);
    run("div_zero",   OP_DIV,   32'hFFFF_FFFB, 32'd0,         64'hFFFF_FFFB_FFFF_FFFF, LAT_DIV);
    run("divu_zero",  OP_DIVU,  32'h1234_5678, 32'd0,         64'h1234_5678_FFFF_FFFF, LAT_DIV);

    // Start and MTHI while busy are both ignored.
    issue(OP_DIVU, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 1'b1, LAT_DIV);
    repeat (5) @(negedge clk);
    start = 1'b1;
    op    = OP_MULTU;
    src_a = 32'd2;
    src_b = 32'd2;
    hi_we = 1'b1;
    wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0;
    hi_we = 1'b0;
    chk("busy_ignore_busy", 64'(busy), 64'd1);
    chk("busy_ignore_hilo", {hi, lo}, 64'h1234_5678_FFFF_FFFF);
    wait_idle("divu_100_7");

    // MTHI while idle.
    hi_we = 1'b1;
    wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    hi_we = 1'b0;
    chk("mthi", {hi, lo}, 64'hDEAD_BEEF_0000_000E);

    // MTHI and MTLO together.
    hi_we = 1'b1;
    lo_we = 1'b1;
    wdata = 32'h5A5A_5A5A;
    @(negedge clk);
    hi_we = 1'b0;
    lo_we = 1'b0;
    chk("mthi_mtlo", {hi, lo}, 64'h5A5A_5A5A_5A5A_5A5A);

    // Start wins over a simultaneous MTHI.
    hi_we = 1'b1;
    wdata = 32'h1111_1111;
    issue(OP_DIVU, 32'd9, 32'd3, 64'h0000_0000_0000_0003, 1'b1, LAT_DIV);
    hi_we = 1'b0;
    @(negedge clk);
    chk("start_wins", {hi, lo}, 64'h5A5A_5A5A_5A5A_5A5A);
    wait_idle("divu_9_3_a");

    // Reset mid-operation aborts it without writing a result.
    hi_we = 1'b1;
    lo_we = 1'b1;
    wdata = 32'hCAFE_F00D;
    @(negedge clk);
    hi_we = 1'b0;
    lo_we = 1'b0;
    issue(OP_MULT, 32'd5, 32'd5, 64'd0, 1'b0, LAT_MUL);
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run("divu_9_3_b", OP_DIVU, 32'd9, 32'd3, 64'h0000_0000_0000_0003, LAT_DIV);

    repeat (3) @(negedge clk);
    chk("drain", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
